mchan_resp_demux: RTL
=====================

// Module: mchan_resp_demux
// PURPOSE
//  Response-side counterpart of the mchan req/gnt arbitration tree.
//  - Input: one merged response stream carrying data and id.
//  - Routing: the low id bits select one of N_PORTS initiators.
//  - Output: each port has its own FIFO_DEPTH-deep elastic buffer.
//  - Backpressure on one port never blocks traffic bound for the other ports.
// PARAMETERS
//  DATA_WIDTH  32  payload width
//  ID_WIDTH    4   id width; carried unchanged to the outputs
//  N_PORTS     4   initiator count; power of 2, 2 <= N_PORTS <= 2**ID_WIDTH
//  FIFO_DEPTH  2   entries per port FIFO; power of 2, >= 2
// PORTS
//  clk_i    in   1                     clock; all state updates on rising edge
//  rst_ni   in   1                     synchronous reset, active-low
//  req_i    in   1                     upstream response valid
//  gnt_o    out  1                     upstream response accepted
//  data_i   in   DATA_WIDTH            upstream payload
//  id_i     in   ID_WIDTH              upstream id; [PW-1:0] = dest port, PW=$clog2(N_PORTS)
//  req_o    out  N_PORTS               per-port response valid
//  gnt_i    in   N_PORTS               per-port response consumed
//  data_o   out  N_PORTS*DATA_WIDTH    per-port payload, port k at [k*DATA_WIDTH +: DATA_WIDTH]
//  id_o     out  N_PORTS*ID_WIDTH      per-port id, port k at [k*ID_WIDTH +: ID_WIDTH]
// BEHAVIOUR
//  Reset (rst_ni=0 at a clock edge)
//   - All FIFOs empty; wr/rd pointers and counts cleared to 0.
//   - req_o = 0; data_o / id_o = 0 (storage cleared).
//   - gnt_o = req_i in the cycle after reset, since all FIFOs are empty.
//   - Reset mid-transfer discards all buffered entries; no response is replayed.
//  Routing and accept
//   - sel = id_i[PW-1:0].
//   - gnt_o = req_i & (cnt[sel] != FIFO_DEPTH). Combinational from req_i, id_i and state only.
//   - Push into FIFO[sel] when req_i & gnt_o. Payload and full id are stored.
//   - No pass-through: a full FIFO is never granted, even if that port pops in the same cycle.
//  Output drain
//   - req_o[k] = (cnt[k] != 0). data_o / id_o show the head entry of FIFO[k] (registered).
//   - Pop FIFO[k] when req_o[k] & gnt_i[k].
//   - gnt_i[k] while req_o[k]=0 is ignored.
//   - Head data is held stable while req_o[k]=1 and gnt_i[k]=0.
//  Latency and throughput
//   - Min latency: accepted at edge t -> req_o[sel]=1 from t+1.
//   - Full throughput per port: 1 push + 1 pop per cycle when not full.
//  Counters and pointers
//   - cnt[k] is $clog2(FIFO_DEPTH)+1 bits.
//   - Simultaneous push and pop on port k: cnt unchanged, both pointers advance.
//   - Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally from FIFO_DEPTH-1 to 0.
//  Ordering
//   - Per-port order is FIFO order.
//   - No ordering relation between different ports.
//  Protocol assumption
//   - Upstream holds req_i, data_i and id_i stable until gnt_o.
//   - An assertion flags any change of data_i or id_i while req_i & ~gnt_o.
//   - Only id_i[PW-1:0] affects routing; the upper id bits are passthrough.
// TESTING
//  1 Reset: hold rst_ni=0 for 3 cycles with req_i=1.
//    -> req_o=0, data_o=0, id_o=0 throughout; first cycle after release gnt_o=1.
//  2 Route: push id=4'h2 data=32'hA5A5_0002, all gnt_i=1.
//    -> next cycle req_o=4'b0100, port2 data=32'hA5A5_0002 id=4'h2; popped one cycle later.
//  3 Full: gnt_i=0, push 3 beats with id=4'h1, FIFO_DEPTH=2.
//    -> beats 1-2 granted, third sees gnt_o=0 until gnt_i[1]=1.
//    -> port1 then drains beat1, beat2, beat3 in order.
//  4 Isolation: port1 full and stalled; present id=4'h3.
//    -> gnt_o=1 at once; req_o[3] rises next cycle while port1 stays at cnt=2.
//  5 Wrap/throughput: 64 back-to-back beats to port0, gnt_i[0]=1 every cycle.
//    -> gnt_o=1 every cycle; output order matches input; pointers wrap correctly.
//  6 Reset mid-op: 2 entries buffered in each port, pulse rst_ni=0 for 1 cycle.
//    -> req_o=0 next cycle; no stale data after reset release.

Source files
------------

// File: rtl/mchan_resp_demux.sv
// rtl/mchan_resp_demux.sv - routes one response stream into per-port elastic FIFOs by id
module mchan_resp_demux #(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int N_PORTS    = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           req_i,
  output logic                           gnt_o,
  input  logic [DATA_WIDTH-1:0]          data_i,
  input  logic [ID_WIDTH-1:0]            id_i,
  output logic [N_PORTS-1:0]             req_o,
  input  logic [N_PORTS-1:0]             gnt_i,
  output logic [N_PORTS*DATA_WIDTH-1:0]  data_o,
  output logic [N_PORTS*ID_WIDTH-1:0]    id_o
);

  localparam int PW = $clog2(N_PORTS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [PW-1:0]         sel;
  logic [N_PORTS-1:0]    push;
  logic [N_PORTS-1:0]    pop;

  logic [CW-1:0]         cnt_q    [N_PORTS];
  logic [CW-1:0]         cnt_d    [N_PORTS];
  logic [AW-1:0]         wr_ptr_q [N_PORTS];
  logic [AW-1:0]         wr_ptr_d [N_PORTS];
  logic [AW-1:0]         rd_ptr_q [N_PORTS];
  logic [AW-1:0]         rd_ptr_d [N_PORTS];
  logic [DATA_WIDTH-1:0] data_mem_q [N_PORTS][FIFO_DEPTH];
  logic [ID_WIDTH-1:0]   id_mem_q   [N_PORTS][FIFO_DEPTH];

  // Only the low id bits steer; a full destination is never granted, even if it pops this cycle.
  assign sel   = id_i[PW-1:0];
  assign gnt_o = req_i & (cnt_q[sel] != CW'(FIFO_DEPTH));

  // Per-port push/pop decode, head presentation and next pointer/count state.
  always_comb begin
    push   = '0;
    pop    = '0;
    req_o  = '0;
    data_o = '0;
    id_o   = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      push[k]  = req_i & gnt_o & (sel == PW'(k));
      req_o[k] = (cnt_q[k] != '0);
      pop[k]   = req_o[k] & gnt_i[k];
      data_o[k*DATA_WIDTH +: DATA_WIDTH] = data_mem_q[k][rd_ptr_q[k]];
      id_o[k*ID_WIDTH +: ID_WIDTH]       = id_mem_q[k][rd_ptr_q[k]];
      wr_ptr_d[k] = push[k] ? wr_ptr_q[k] + AW'(1) : wr_ptr_q[k];
      rd_ptr_d[k] = pop[k]  ? rd_ptr_q[k] + AW'(1) : rd_ptr_q[k];
      cnt_d[k]    = cnt_q[k] + CW'(push[k]) - CW'(pop[k]);
    end
  end

  // FIFO state and storage; reset clears storage so outputs read zero afterwards.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int k = 0; k < N_PORTS; k++) begin
        cnt_q[k]    <= '0;
        wr_ptr_q[k] <= '0;
        rd_ptr_q[k] <= '0;
        for (int e = 0; e < FIFO_DEPTH; e++) begin
          data_mem_q[k][e] <= '0;
          id_mem_q[k][e]   <= '0;
        end
      end
    end else begin
      for (int k = 0; k < N_PORTS; k++) begin
        cnt_q[k]    <= cnt_d[k];
        wr_ptr_q[k] <= wr_ptr_d[k];
        rd_ptr_q[k] <= rd_ptr_d[k];
        if (push[k]) begin
          data_mem_q[k][wr_ptr_q[k]] <= data_i;
          id_mem_q[k][wr_ptr_q[k]]   <= id_i;
        end
      end
    end
  end

  // Upstream must keep payload and id stable while its response waits for a grant.
  a_req_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (req_i && !gnt_o) |=> ($stable(data_i) && $stable(id_i)));

endmodule
